// File: rtl/aes_port_pkg.sv
// Shared link constants for the AES block transmitter/receiver pair.
// The receiver state type lives here so both ends of the link agree on it.
package aes_port_pkg;

  localparam int BLOCK_BYTES     = 16;
  localparam int BYTE_W          = 8;
  localparam int BLOCK_W         = 128;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_t;

endpackage

// File: rtl/aes_rx_strobe.sv
// Toggle-strobe decoder: a byte is offered whenever shakehand changes level.
// sh_q tracks the line every cycle, even while reception is disabled.
module aes_rx_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic shakehand,
  output logic accept
);

  logic sh_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sh_q <= 1'b1;
    else        sh_q <= shakehand;
  end

  assign accept = en & (shakehand ^ sh_q);

endmodule

// File: rtl/aes_rx.sv
// Receives 16 toggle-strobed bytes into a 128-bit block and pushes it to a FIFO,
// with a one-entry holding register for backpressure and sticky error flags.
module aes_rx
  import aes_port_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [BYTE_W-1:0]  rx,
  input  logic               shakehand,
  input  logic               full,
  output logic               push,
  output logic [BLOCK_W-1:0] data,
  output logic               overflow,
  output logic               timeout_err
);

  localparam int            IW        = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

  rx_state_t          state;
  logic [3:0]         cnt;
  logic [IW-1:0]      idle_cnt;
  logic [BLOCK_W-1:0] shift_buf;
  logic               pend_valid;
  logic [BLOCK_W-1:0] pend_data;

  logic               accept;
  logic [3:0]         lane;
  logic               complete;
  logic               drain;
  logic [BLOCK_W-1:0] block_next;

  aes_rx_strobe u_strobe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .shakehand (shakehand),
    .accept    (accept)
  );

  // First byte lands in the top lane so the block reads MSB-first.
  assign lane     = 4'd15 - cnt;
  assign complete = accept && (cnt == 4'd15);
  assign drain    = pend_valid && !full;

  always_comb begin
    block_next = shift_buf;
    block_next[{lane, 3'b000} +: BYTE_W] = rx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      idle_cnt    <= '0;
      shift_buf   <= '0;
      pend_valid  <= 1'b0;
      pend_data   <= '0;
      push        <= 1'b0;
      data        <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      push <= 1'b0;

      if (!en) begin
        state    <= ST_IDLE;
        cnt      <= 4'd0;
        idle_cnt <= '0;
      end else if (accept) begin
        shift_buf <= block_next;
        cnt       <= cnt + 4'd1;
        idle_cnt  <= '0;
        state     <= complete ? ST_IDLE : ST_RECV;
      end else if (state == ST_RECV) begin
        if (idle_cnt == IDLE_LAST) begin
          state       <= ST_IDLE;
          cnt         <= 4'd0;
          idle_cnt    <= '0;
          timeout_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + IDLE_ONE;
        end
      end

      // Output path: direct push, park in pend, swap through pend, or drop.
      if (complete) begin
        if (!full && !pend_valid) begin
          push <= 1'b1;
          data <= block_next;
        end else if (!pend_valid) begin
          pend_valid <= 1'b1;
          pend_data  <= block_next;
        end else if (drain) begin
          push      <= 1'b1;
          data      <= pend_data;
          pend_data <= block_next;
        end else begin
          overflow <= 1'b1;
        end
      end else if (drain) begin
        push       <= 1'b1;
        data       <= pend_data;
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_rx.sv
// Directed-sequence bench for aes_rx with random block contents, checked against
// a byte/block-level reference model and a scoreboard of expected pushes.
module tb_aes_rx;

  localparam int TMO = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [7:0]   rx;
  logic         shakehand;
  logic         full;
  logic         push;
  logic [127:0] data;
  logic         overflow;
  logic         timeout_err;

  aes_rx #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rx          (rx),
    .shakehand   (shakehand),
    .full        (full),
    .push        (push),
    .data        (data),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  logic [7:0]   m_bytes[$];
  bit           m_pend;
  logic [127:0] m_pend_blk;
  bit           m_ovf;
  bit           m_tmo;
  logic         sh;
  int           n_checks = 0;
  int           n_pass   = 0;
  int           push_while_full = 0;

  // monitor: collects every push and flags a push during a full cycle
  always @(posedge clk) begin
    #1;
    if (push === 1'b1) begin
      got_q.push_back(data);
      if (full === 1'b1) push_while_full++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // reference model: a completed block goes out, or waits, or is lost
  task automatic model_complete(input logic [127:0] blk);
    if (!full && !m_pend) exp_q.push_back(blk);
    else if (!m_pend) begin
      m_pend     = 1'b1;
      m_pend_blk = blk;
    end else if (!full) begin
      exp_q.push_back(m_pend_blk);
      m_pend_blk = blk;
    end else m_ovf = 1'b1;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    logic [127:0] blk;
    @(negedge clk);
    rx        = b;
    sh        = ~sh;
    shakehand = sh;
    if (en) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 16) begin
        blk = '0;
        for (int i = 0; i < 16; i++) blk = {blk[119:0], m_bytes[i]};
        m_bytes.delete();
        model_complete(blk);
      end
    end
  endtask

  task automatic send_block(input logic [127:0] blk);
    for (int i = 15; i >= 0; i--) send_byte(blk[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_full();
    @(negedge clk);
    full = 1'b0;
    if (m_pend) begin
      exp_q.push_back(m_pend_blk);
      m_pend = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    shakehand = 1'b1;
    sh        = 1'b1;
    idle(2);
    m_bytes.delete();
    exp_q.delete();
    got_q.delete();
    m_pend = 1'b0;
    m_ovf  = 1'b0;
    m_tmo  = 1'b0;
  endtask

  task automatic compare_pushes(input string tag);
    check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check({tag, "_overflow"}, 128'(overflow), 128'(m_ovf));
    check({tag, "_timeout"}, 128'(timeout_err), 128'(m_tmo));
  endtask

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] b0;

  initial begin
    rst_n = 1'b0; en = 1'b0; rx = '0; shakehand = 1'b1; full = 1'b0; sh = 1'b1;
    m_pend = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0; m_pend_blk = '0;
    idle(3);
    check("reset_push", 128'(push), 128'(0));
    check("reset_data", data, 128'(0));
    check("reset_overflow", 128'(overflow), 128'(0));
    check("reset_timeout", 128'(timeout_err), 128'(0));
    @(negedge clk); rst_n = 1'b1; en = 1'b1;
    idle(2);

    // single loop-back block, one-cycle latency
    b0 = 128'h00112233445566778899AABBCCDDEEFF;
    send_block(b0);
    @(negedge clk);
    check("single_push_latency", 128'(push), 128'(1));
    check("single_push_data", data, b0);
    @(negedge clk);
    check("single_push_once", 128'(push), 128'(0));
    compare_pushes("single");

    // three back-to-back random blocks
    for (int k = 0; k < 3; k++) send_block(rand_block());
    idle(3);
    compare_pushes("b2b");

    // full held over two completions, then released
    @(negedge clk); full = 1'b1;
    send_block(rand_block());
    send_block(rand_block());
    idle(3);
    check("full_no_push", 128'(got_q.size()), 128'(0));
    check("full_overflow", 128'(overflow), 128'(1));
    release_full();
    idle(3);
    compare_pushes("full_release");

    // partial block abandoned by silence
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    idle(TMO);
    check("timeout_not_yet", 128'(timeout_err), 128'(0));
    idle(1);
    m_tmo = 1'b1;
    m_bytes.delete();
    check("timeout_set", 128'(timeout_err), 128'(1));
    b0 = rand_block();
    for (int i = 15; i >= 0; i--) begin
      send_byte(b0[i*8 +: 8]);
      idle($urandom_range(0, 3));
    end
    idle(3);
    compare_pushes("after_timeout");

    // enable dropped mid-block
    for (int i = 0; i < 9; i++) send_byte(8'($urandom));
    @(negedge clk); en = 1'b0;
    m_bytes.delete();
    idle(2);
    @(negedge clk); en = 1'b1;
    send_block(rand_block());
    idle(3);
    compare_pushes("en_drop");

    // reset with a parked block and a partial block
    @(negedge clk); full = 1'b1;
    send_block(rand_block());
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    apply_reset();
    check("rst_push", 128'(push), 128'(0));
    check("rst_data", data, 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_timeout", 128'(timeout_err), 128'(0));
    rst_n = 1'b1;
    full  = 1'b0;
    @(negedge clk);
    check("rst_release_no_push", 128'(push), 128'(0));
    got_q.delete();
    send_block(rand_block());
    idle(3);
    compare_pushes("after_reset");

    check("push_while_full", 128'(push_while_full), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
